mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_lane.sv | 50 +++++
 rtl/mem_bridge.sv | 141 ++++++++++++++
 tb/tb_mem_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared bus definitions for the core-to-RAM bridge and other bus agents.
// Size codes travel on MEM_ByteEnable; state encodings are used by mem_bridge.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering between the 32-bit core bus and a 32-bit RAM word:
// write strobes/replicated data, misalignment check, and read extraction.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  i_wr_size,
  input  logic [1:0]  i_wr_addr_lo,
  input  logic [31:0] i_wr_data,
  input  logic [1:0]  i_rd_size,
  input  logic [1:0]  i_rd_addr_lo,
  input  logic [31:0] i_rd_data,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_we      = 4'b0000;
    o_wdata   = 32'h0;
    o_illegal = 1'b0;
    case (i_wr_size)
      SZ_BYTE: begin
        o_we    = 4'b0001 << i_wr_addr_lo;
        o_wdata = {4{i_wr_data[7:0]}};
      end
      SZ_HALF: begin
        o_we      = i_wr_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wr_data[15:0]}};
        o_illegal = i_wr_addr_lo[0];
      end
      SZ_WORD: begin
        o_we      = 4'b1111;
        o_wdata   = i_wr_data;
        o_illegal = |i_wr_addr_lo;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_rdata = 32'h0;
    case (i_rd_size)
      SZ_BYTE: o_rdata = {24'h0, i_rd_data[{i_rd_addr_lo, 3'b000} +: 8]};
      SZ_HALF: o_rdata = {16'h0, (i_rd_addr_lo[1] ? i_rd_data[31:16] : i_rd_data[15:0])};
      default: o_rdata = i_rd_data;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Core bus to synchronous single-port RAM bridge: accept, RAM access, fixed
// read wait, then a one-cycle completion pulse (with error for misaligned access).
module mem_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MEM_Cmd,
  input  logic              MEM_We,
  input  logic [1:0]        MEM_ByteEnable,
  input  logic [31:0]       MEM_Addr,
  input  logic [31:0]       MEM_DataOut,
  output logic              MEM_Ready,
  output logic [31:0]       MEM_DataIn,
  output logic              MEM_DataReady,
  output logic              MEM_Err,
  output logic              RAM_En,
  output logic [3:0]        RAM_We,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic [31:0]       RAM_WData,
  input  logic [31:0]       RAM_RData
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic [3:0]        r_cnt;
  logic [31:0]       r_data_in;
  logic              r_data_ready;
  logic              r_err;
  logic              r_ram_en;
  logic [3:0]        r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;

  logic [3:0]        w_lane_we;
  logic [31:0]       w_lane_wdata;
  logic              w_illegal;
  logic [31:0]       w_lane_rdata;
  logic              w_unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap in the RAM.
  assign w_unused_addr = ^MEM_Addr[31:ADDR_W+2];

  mem_lane u_lane (
    .i_wr_size    (MEM_ByteEnable),
    .i_wr_addr_lo (MEM_Addr[1:0]),
    .i_wr_data    (MEM_DataOut),
    .i_rd_size    (r_size),
    .i_rd_addr_lo (r_addr_lo),
    .i_rd_data    (RAM_RData),
    .o_we         (w_lane_we),
    .o_wdata      (w_lane_wdata),
    .o_illegal    (w_illegal),
    .o_rdata      (w_lane_rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_addr_lo    <= 2'b00;
      r_cnt        <= 4'd0;
      r_data_in    <= 32'h0;
      r_data_ready <= 1'b0;
      r_err        <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 4'b0000;
      r_ram_addr   <= '0;
      r_ram_wdata  <= 32'h0;
    end else begin
      r_data_ready <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (MEM_Cmd) begin
            r_we      <= MEM_We;
            r_size    <= MEM_ByteEnable;
            r_addr_lo <= MEM_Addr[1:0];
            if (w_illegal) begin
              r_state      <= ST_DONE;
              r_data_ready <= 1'b1;
              r_err        <= 1'b1;
              r_data_in    <= 32'h0;
            end else begin
              r_state    <= ST_ACCESS;
              r_ram_en   <= 1'b1;
              r_ram_addr <= MEM_Addr[ADDR_W+1:2];
              if (MEM_We) begin
                r_ram_we    <= w_lane_we;
                r_ram_wdata <= w_lane_wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          r_ram_en    <= 1'b0;
          r_ram_we    <= 4'b0000;
          r_ram_addr  <= '0;
          r_ram_wdata <= 32'h0;
          if (r_we) begin
            r_state      <= ST_DONE;
            r_data_ready <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          // Terminal count: RAM data has been valid for the full latency.
          if (r_cnt == 4'd0) begin
            r_data_in    <= w_lane_rdata;
            r_state      <= ST_DONE;
            r_data_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MEM_Ready     = (r_state == ST_IDLE) && !Reset;
  assign MEM_DataIn    = r_data_in;
  assign MEM_DataReady = r_data_ready;
  assign MEM_Err       = r_err;
  assign RAM_En        = r_ram_en;
  assign RAM_We        = r_ram_we;
  assign RAM_Addr      = r_ram_addr;
  assign RAM_WData     = r_ram_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: one instance with WAIT_CYCLES=1 driven by directed and
// random transactions against a byte-array reference, one with WAIT_CYCLES=3.
module tb_mem_bridge;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Instance with WAIT_CYCLES=1
  logic        reset_1 = 1'b1;
  logic        cmd_1 = 1'b0, we_1 = 1'b0;
  logic [1:0]  be_1 = 2'b00;
  logic [31:0] addr_1 = 32'h0, dout_1 = 32'h0;
  logic        ready_1, drdy_1, err_1, ram_en_1;
  logic [31:0] din_1, ram_wdata_1, ram_rdata_1;
  logic [3:0]  ram_we_1;
  logic [11:0] ram_addr_1;

  // Instance with WAIT_CYCLES=3
  logic        reset_3 = 1'b1;
  logic        cmd_3 = 1'b0, we_3 = 1'b0;
  logic [1:0]  be_3 = 2'b00;
  logic [31:0] addr_3 = 32'h0, dout_3 = 32'h0;
  logic        ready_3, drdy_3, err_3, ram_en_3;
  logic [31:0] din_3, ram_wdata_3, ram_rdata_3;
  logic [3:0]  ram_we_3;
  logic [11:0] ram_addr_3;

  mem_bridge #(.ADDR_W(12), .WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(reset_1), .MEM_Cmd(cmd_1), .MEM_We(we_1),
    .MEM_ByteEnable(be_1), .MEM_Addr(addr_1), .MEM_DataOut(dout_1),
    .MEM_Ready(ready_1), .MEM_DataIn(din_1), .MEM_DataReady(drdy_1), .MEM_Err(err_1),
    .RAM_En(ram_en_1), .RAM_We(ram_we_1), .RAM_Addr(ram_addr_1),
    .RAM_WData(ram_wdata_1), .RAM_RData(ram_rdata_1));

  mem_bridge #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset(reset_3), .MEM_Cmd(cmd_3), .MEM_We(we_3),
    .MEM_ByteEnable(be_3), .MEM_Addr(addr_3), .MEM_DataOut(dout_3),
    .MEM_Ready(ready_3), .MEM_DataIn(din_3), .MEM_DataReady(drdy_3), .MEM_Err(err_3),
    .RAM_En(ram_en_3), .RAM_We(ram_we_3), .RAM_Addr(ram_addr_3),
    .RAM_WData(ram_wdata_3), .RAM_RData(ram_rdata_3));

  // Synchronous RAMs with one cycle of read latency; data held until next read.
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];

  always @(posedge Clk) begin
    if (ram_en_1) begin
      if (|ram_we_1) begin
        for (int j = 0; j < 4; j++)
          if (ram_we_1[j]) mem1[ram_addr_1][8*j +: 8] <= ram_wdata_1[8*j +: 8];
      end else begin
        ram_rdata_1 <= mem1[ram_addr_1];
      end
    end
  end

  always @(posedge Clk) begin
    if (ram_en_3) begin
      if (|ram_we_3) begin
        for (int j = 0; j < 4; j++)
          if (ram_we_3[j]) mem3[ram_addr_3][8*j +: 8] <= ram_wdata_3[8*j +: 8];
      end else begin
        ram_rdata_3 <= mem3[ram_addr_3];
      end
    end
  end

  // Reference: flat 16 KiB byte array plus the last value a read returned.
  logic [7:0]  ref_bytes [0:16383];
  logic [31:0] ref_last_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on dut1, started and finished at a negedge with the bridge idle.
  task automatic txn1(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] data);
    bit          illegal;
    int          nb, lat, k;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd, exp_rd;
    illegal = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    nb      = 1 << sz;
    exp_we  = 4'b0000;
    exp_wd  = 32'h0;
    if (!illegal) begin
      for (int b = 0; b < nb; b++) exp_we[int'(addr[1:0]) + b] = 1'b1;
      for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = 8'(data >> (8 * (j % nb)));
    end
    lat = illegal ? 1 : (we ? 2 : 3);

    check("ready_idle", {31'h0, ready_1}, 32'h1);
    cmd_1 = 1'b1; we_1 = we; be_1 = sz; addr_1 = addr; dout_1 = data;
    @(posedge Clk);
    @(negedge Clk);
    cmd_1 = 1'b0; we_1 = ~we; be_1 = 2'($urandom); addr_1 = $urandom; dout_1 = $urandom;
    k = 1;
    if (!illegal) begin
      check("access_en", {31'h0, ram_en_1}, 32'h1);
      check("access_addr", {20'h0, ram_addr_1}, (addr >> 2) % 4096);
      check("access_we", {28'h0, ram_we_1}, we ? {28'h0, exp_we} : 32'h0);
      if (we) check("access_wdata", ram_wdata_1, exp_wd);
    end else begin
      check("illegal_no_en", {31'h0, ram_en_1}, 32'h0);
    end
    while (drdy_1 !== 1'b1 && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check("latency", k, lat);
    check("err", {31'h0, err_1}, {31'h0, illegal});

    if (illegal) begin
      ref_last_rd = 32'h0;
    end else if (we) begin
      for (int b = 0; b < nb; b++) ref_bytes[(addr + b) % 16384] = 8'(data >> (8 * b));
    end else begin
      exp_rd = 32'h0;
      for (int b = 0; b < nb; b++) exp_rd |= 32'(ref_bytes[(addr + b) % 16384]) << (8 * b);
      ref_last_rd = exp_rd;
    end
    check("data_in", din_1, ref_last_rd);

    @(negedge Clk);
    check("pulse_width", {31'h0, drdy_1}, 32'h0);
    check("err_outside_done", {31'h0, err_1}, 32'h0);
    check("ready_after_done", {31'h0, ready_1}, 32'h1);
  endtask

  initial begin
    int k, pulses;
    logic [1:0]  sz;
    logic [31:0] a;

    for (int i = 0; i < 4096; i++) begin
      mem1[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = 8'(mem1[i] >> (8 * b));
      mem3[i] = 32'h0;
    end
    mem3[5] = 32'h1234_5678;

    // Reset state
    @(negedge Clk);
    check("rst_ready", {31'h0, ready_1}, 32'h0);
    check("rst_din", din_1, 32'h0);
    check("rst_drdy", {31'h0, drdy_1}, 32'h0);
    check("rst_err", {31'h0, err_1}, 32'h0);
    check("rst_ram_en", {31'h0, ram_en_1}, 32'h0);
    check("rst_ram_we", {28'h0, ram_we_1}, 32'h0);
    check("rst_ram_addr", {20'h0, ram_addr_1}, 32'h0);
    check("rst_ram_wdata", ram_wdata_1, 32'h0);
    check("rst_ready_3", {31'h0, ready_3}, 32'h0);
    reset_1 = 1'b0;
    reset_3 = 1'b0;
    #1;
    check("ready_on_release", {31'h0, ready_1}, 32'h1);
    @(negedge Clk);
    check("ready_one_cycle_after", {31'h0, ready_3}, 32'h1);

    // Directed cases
    txn1(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
    txn1(1'b1, 2'b00, 32'h13, 32'h0000_00A5);
    txn1(1'b0, 2'b10, 32'h10, 32'h0);
    check("byte_merge_read", din_1, 32'hA5AD_BEEF);
    txn1(1'b1, 2'b10, 32'h10, 32'h8001_7FFF);
    txn1(1'b0, 2'b01, 32'h12, 32'h0);
    check("half_read_hi", din_1, 32'h0000_8001);
    txn1(1'b0, 2'b10, 32'h6, 32'h0);
    txn1(1'b0, 2'b01, 32'h1, 32'h0);
    txn1(1'b1, 2'b11, 32'h8, 32'h1234_5678);
    txn1(1'b1, 2'b10, 32'h0000_4010, 32'hCAFE_F00D);
    txn1(1'b0, 2'b10, 32'h10, 32'h0);
    check("wrap_readback", din_1, 32'hCAFE_F00D);

    // Command held high: exactly one accept per IDLE visit
    cmd_1 = 1'b1; we_1 = 1'b1; be_1 = 2'b10; addr_1 = 32'h40; dout_1 = 32'h0BAD_CAFE;
    for (int i = 0; i < 4; i++) begin
      check("hold_ready_idle", {31'h0, ready_1}, 32'h1);
      @(negedge Clk);
      check("hold_ready_access", {31'h0, ready_1}, 32'h0);
      check("hold_access_en", {31'h0, ram_en_1}, 32'h1);
      @(negedge Clk);
      check("hold_ready_done", {31'h0, ready_1}, 32'h0);
      check("hold_drdy", {31'h0, drdy_1}, 32'h1);
      @(negedge Clk);
    end
    cmd_1 = 1'b0;
    for (int b = 0; b < 4; b++) ref_bytes[32'h40 + b] = 8'(32'h0BAD_CAFE >> (8 * b));
    txn1(1'b0, 2'b10, 32'h40, 32'h0);

    // Random traffic, mostly aligned, across a 64 KiB window to exercise wrap
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 32'hFFFF);
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'b01) a = a & ~32'h1;
        if (sz == 2'b10) a = a & ~32'h3;
      end
      txn1(1'($urandom), sz, a, $urandom);
    end

    // WAIT_CYCLES=3: read latency 5
    cmd_3 = 1'b1; we_3 = 1'b0; be_3 = 2'b10; addr_3 = 32'h14;
    @(negedge Clk);
    cmd_3 = 1'b0;
    k = 1;
    while (drdy_3 !== 1'b1 && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check("w3_latency", k, 5);
    check("w3_data", din_3, 32'h1234_5678);
    @(negedge Clk);

    // Reset during WAIT abandons the read
    cmd_3 = 1'b1; be_3 = 2'b00; addr_3 = 32'h17;
    @(negedge Clk);
    cmd_3 = 1'b0;
    @(negedge Clk);
    reset_3 = 1'b1;
    #1;
    check("w3_rst_ready", {31'h0, ready_3}, 32'h0);
    check("w3_rst_din", din_3, 32'h0);
    check("w3_rst_en", {31'h0, ram_en_3}, 32'h0);
    @(negedge Clk);
    reset_3 = 1'b0;
    #1;
    check("w3_ready_release", {31'h0, ready_3}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (drdy_3 === 1'b1) pulses++;
    end
    check("w3_no_completion", pulses, 0);
    check("w3_ready_settled", {31'h0, ready_3}, 32'h1);

    // Reset during ACCESS drops RAM_We without waiting for a clock
    cmd_3 = 1'b1; we_3 = 1'b1; be_3 = 2'b10; addr_3 = 32'h20; dout_3 = 32'h5555_AAAA;
    @(negedge Clk);
    cmd_3 = 1'b0;
    check("w3_access_we", {28'h0, ram_we_3}, 32'hF);
    reset_3 = 1'b1;
    #1;
    check("w3_async_we_drop", {28'h0, ram_we_3}, 32'h0);
    @(negedge Clk);
    reset_3 = 1'b0;
    @(negedge Clk);
    check("w3_no_drdy_after", {31'h0, drdy_3}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
